// File: rtl/axi4_mem_pkg.sv
// rtl/axi4_mem_pkg.sv - Burst/response encodings and FSM state types for the AXI4 memory slave.
package axi4_mem_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

endpackage

// File: rtl/axi4_burst_addr.sv
// rtl/axi4_burst_addr.sv - Next-beat address for FIXED/INCR/WRAP bursts, with size clamped to the bus width.
module axi4_burst_addr
    import axi4_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            len,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);

    logic [2:0]            eff_size;
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] incr_addr;

    always_comb begin
        eff_size  = (size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : size;
        step      = ADDR_WIDTH'(1) << eff_size;
        wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << eff_size) - ADDR_WIDTH'(1);
        incr_addr = addr + step;
        // Reserved encoding falls through to INCR.
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi4_mem_slave.sv
// rtl/axi4_mem_slave.sv - AXI4 memory slave, one outstanding burst per read/write path.
// Define AXI4_MEM_SLVERR_EN to answer out-of-range word indices with SLVERR instead of aliasing modulo DEPTH.
module axi4_mem_slave
    import axi4_mem_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 1024
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
    localparam int IDX_WIDTH  = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    w_state_t              w_state;
    logic [ADDR_WIDTH-1:0] w_addr, w_next;
    logic [7:0]            w_len, w_cnt;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic                  w_err, w_fire, w_ok, w_beat_err;
    logic [IDX_WIDTH-1:0]  w_idx;

    r_state_t              r_state;
    logic [ADDR_WIDTH-1:0] r_addr, rd_addr, rd_next;
    logic [7:0]            r_len, r_cnt, rd_len;
    logic [2:0]            r_size, rd_size;
    logic [1:0]            r_burst, rd_burst, rd_resp;
    logic                  r_idle, rd_ok;
    logic [DATA_WIDTH-1:0] rd_word;

    assign w_fire     = wvalid && wready;
    assign w_idx      = w_addr[ADDR_LSB +: IDX_WIDTH];
    assign w_beat_err = (wlast != (w_cnt == w_len)) || !w_ok;

    // While idle the read path looks at the AR channel so the first beat can be fetched on the handshake edge.
    assign r_idle   = (r_state == R_IDLE);
    assign rd_addr  = r_idle ? araddr  : r_addr;
    assign rd_len   = r_idle ? arlen   : r_len;
    assign rd_size  = r_idle ? arsize  : r_size;
    assign rd_burst = r_idle ? arburst : r_burst;

`ifdef AXI4_MEM_SLVERR_EN
    assign w_ok  = ((w_addr  >> (ADDR_LSB + IDX_WIDTH)) == '0);
    assign rd_ok = ((rd_addr >> (ADDR_LSB + IDX_WIDTH)) == '0);
`else
    assign w_ok  = 1'b1;
    assign rd_ok = 1'b1;
`endif

    assign rd_word = rd_ok ? mem[rd_addr[ADDR_LSB +: IDX_WIDTH]] : '0;
    assign rd_resp = rd_ok ? RESP_OKAY : RESP_SLVERR;

    axi4_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_w_addr (
        .addr(w_addr), .len(w_len), .size(w_size), .burst(w_burst), .next_addr(w_next)
    );

    axi4_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_r_addr (
        .addr(rd_addr), .len(rd_len), .size(rd_size), .burst(rd_burst), .next_addr(rd_next)
    );

    always_ff @(posedge aclk) begin
        if (w_fire && w_ok) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (wstrb[b]) mem[w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= RESP_OKAY;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        bid     <= awid;
                        w_addr  <= awaddr;
                        w_len   <= awlen;
                        w_size  <= awsize;
                        w_burst <= awburst;
                        w_cnt   <= '0;
                        w_err   <= 1'b0;
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        w_state <= W_DATA;
                    end else begin
                        awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_addr <= w_next;
                        w_cnt  <= w_cnt + 8'd1;
                        w_err  <= w_err | w_beat_err;
                        if (w_cnt == w_len) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bresp   <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid && bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        rid     <= arid;
                        r_addr  <= rd_next;
                        r_len   <= arlen;
                        r_size  <= arsize;
                        r_burst <= arburst;
                        r_cnt   <= '0;
                        rdata   <= rd_word;
                        rresp   <= rd_resp;
                        rlast   <= (arlen == 8'd0);
                        rvalid  <= 1'b1;
                        arready <= 1'b0;
                        r_state <= R_DATA;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rvalid && rready) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            rdata  <= rd_word;
                            rresp  <= rd_resp;
                            r_addr <= rd_next;
                            r_cnt  <= r_cnt + 8'd1;
                            rlast  <= ((r_cnt + 8'd1) == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_mem_slave.sv
// tb/tb_axi4_mem_slave.sv - Directed scoreboard bench for axi4_mem_slave (either AXI4_MEM_SLVERR_EN build).
module tb_axi4_mem_slave;
    import axi4_mem_pkg::*;

    localparam int IDW = 4;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int DEP = 1024;
    localparam int BOUND = 200;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic [IDW-1:0]  awid = '0, arid = '0, bid, rid;
    logic [AW-1:0]   awaddr = '0, araddr = '0;
    logic [7:0]      awlen = '0, arlen = '0;
    logic [2:0]      awsize = '0, arsize = '0;
    logic [1:0]      awburst = '0, arburst = '0, bresp, rresp;
    logic            awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
    logic            bvalid, bready = 1'b0, arvalid = 1'b0, arready;
    logic            rlast, rvalid, rready = 1'b0;
    logic [DW-1:0]   wdata = '0, rdata;
    logic [DW/8-1:0] wstrb = '0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } rbeat_t;

    rbeat_t     exp_r[$];
    logic [1:0] exp_b[$];

    always #5 aclk = ~aclk;

    axi4_mem_slave #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bound_fail(input string tag);
        tests++;
        fails++;
        $display("FAIL timeout %s observed=no handshake expected=handshake within %0d cycles", tag, BOUND);
    endtask

    task automatic push_r(input logic [DW-1:0] data, input logic [1:0] resp);
        rbeat_t e;
        e.data = data;
        e.resp = resp;
        exp_r.push_back(e);
    endtask

    // Beat i carries base+i; wlast is driven only on beat last_beat.
    task automatic write_burst(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input logic [DW-1:0] base,
                               input logic [DW/8-1:0] strb, input int last_beat);
        int n;
        awid = id; awaddr = addr; awlen = len; awsize = 3'd3; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < BOUND) begin @(negedge aclk); n++; end
        if (n >= BOUND) bound_fail("aw");
        @(negedge aclk);
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = base + DW'(i); wstrb = strb; wlast = (i == last_beat); wvalid = 1'b1;
            n = 0;
            while (!wready && n < BOUND) begin @(negedge aclk); n++; end
            if (n >= BOUND) bound_fail("w");
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < BOUND) begin @(negedge aclk); n++; end
        if (n >= BOUND) bound_fail("b");
        check("bresp", DW'(bresp), DW'(exp_b.pop_front()));
        check("bid", DW'(bid), DW'(id));
        @(negedge aclk);
        bready = 1'b0;
    endtask

    task automatic read_burst(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input int stall, input int take);
        int n;
        rbeat_t e;
        arid = id; araddr = addr; arlen = len; arsize = 3'd3; arburst = burst; arvalid = 1'b1;
        rready = (stall == 0);
        n = 0;
        while (!arready && n < BOUND) begin @(negedge aclk); n++; end
        if (n >= BOUND) bound_fail("ar");
        @(negedge aclk);
        arvalid = 1'b0;
        for (int i = 0; i < take; i++) begin
            if (i > 0) check("r_sustain", DW'(rvalid), DW'(1));
            n = 0;
            while (!rvalid && n < BOUND) begin @(negedge aclk); n++; end
            if (n >= BOUND) bound_fail("r");
            e = exp_r.pop_front();
            check("rdata", rdata, e.data);
            check("rresp", DW'(rresp), DW'(e.resp));
            check("rlast", DW'(rlast), DW'(i == int'(len)));
            check("rid", DW'(rid), DW'(id));
            if (i == 0 && stall > 0) begin
                for (int s = 0; s < stall; s++) begin
                    @(negedge aclk);
                    check("rdata_stall", rdata, e.data);
                    check("rvalid_stall", DW'(rvalid), DW'(1));
                end
                rready = 1'b1;
            end
            @(negedge aclk);
        end
        rready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=still running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge aclk);
        check("rst_awready", DW'(awready), DW'(0));
        check("rst_wready", DW'(wready), DW'(0));
        check("rst_bvalid", DW'(bvalid), DW'(0));
        check("rst_arready", DW'(arready), DW'(0));
        check("rst_rvalid", DW'(rvalid), DW'(0));
        check("rst_rlast", DW'(rlast), DW'(0));
        check("rst_rdata", rdata, '0);
        check("rst_bresp", DW'(bresp), DW'(RESP_OKAY));
        aresetn = 1'b1;
        @(negedge aclk);
        check("rel_awready", DW'(awready), DW'(1));
        check("rel_arready", DW'(arready), DW'(1));

        // INCR write and read-back
        exp_b.push_back(RESP_OKAY);
        write_burst(4'h3, 32'h100, 8'd3, BURST_INCR, 64'd1, 8'hFF, 3);
        for (int i = 1; i <= 4; i++) push_r(DW'(i), RESP_OKAY);
        read_burst(4'h5, 32'h100, 8'd3, BURST_INCR, 0, 4);

        // WRAP order 0x18,0x00,0x08,0x10
        exp_b.push_back(RESP_OKAY);
        write_burst(4'h1, 32'h0, 8'd3, BURST_INCR, 64'hA0, 8'hFF, 3);
        push_r(64'hA3, RESP_OKAY); push_r(64'hA0, RESP_OKAY);
        push_r(64'hA1, RESP_OKAY); push_r(64'hA2, RESP_OKAY);
        read_burst(4'h2, 32'h18, 8'd3, BURST_WRAP, 0, 4);

        // Reserved burst behaves as INCR
        push_r(64'd1, RESP_OKAY); push_r(64'd2, RESP_OKAY);
        read_burst(4'h7, 32'h100, 8'd1, 2'b11, 0, 2);

        // Partial strobe with a stalled reader
        exp_b.push_back(RESP_OKAY);
        write_burst(4'h0, 32'h200, 8'd0, BURST_INCR, 64'd0, 8'hFF, 0);
        exp_b.push_back(RESP_OKAY);
        write_burst(4'h0, 32'h200, 8'd0, BURST_INCR, {DW{1'b1}}, 8'h0F, 0);
        push_r(64'h0000_0000_FFFF_FFFF, RESP_OKAY);
        read_burst(4'h4, 32'h200, 8'd0, BURST_INCR, 5, 1);

        // Early wlast: all four beats still land, response is SLVERR
        exp_b.push_back(RESP_SLVERR);
        write_burst(4'h9, 32'h300, 8'd3, BURST_INCR, 64'h10, 8'hFF, 1);
        for (int i = 0; i < 4; i++) push_r(64'h10 + DW'(i), RESP_OKAY);
        read_burst(4'h9, 32'h300, 8'd3, BURST_INCR, 0, 4);

        // FIXED burst keeps hitting one word
        exp_b.push_back(RESP_OKAY);
        write_burst(4'h6, 32'h400, 8'd1, BURST_FIXED, 64'h50, 8'hFF, 1);
        push_r(64'h51, RESP_OKAY);
        read_burst(4'h6, 32'h400, 8'd0, BURST_INCR, 0, 1);

        // Address DEPTH*8
`ifdef AXI4_MEM_SLVERR_EN
        exp_b.push_back(RESP_SLVERR);
        write_burst(4'hA, 32'h2000, 8'd0, BURST_INCR, 64'hDEAD, 8'hFF, 0);
        push_r(64'hA0, RESP_OKAY);
        read_burst(4'hA, 32'h0, 8'd0, BURST_INCR, 0, 1);
        push_r(64'h0, RESP_SLVERR);
        read_burst(4'hA, 32'h2000, 8'd0, BURST_INCR, 0, 1);
`else
        exp_b.push_back(RESP_OKAY);
        write_burst(4'hA, 32'h2000, 8'd0, BURST_INCR, 64'hDEAD, 8'hFF, 0);
        push_r(64'hDEAD, RESP_OKAY);
        read_burst(4'hA, 32'h0, 8'd0, BURST_INCR, 0, 1);
`endif

        // Reset in the middle of a read burst
        push_r(64'd1, RESP_OKAY); push_r(64'd2, RESP_OKAY);
        read_burst(4'hB, 32'h100, 8'd3, BURST_INCR, 0, 2);
        check("pre_rst_rvalid", DW'(rvalid), DW'(1));
        aresetn = 1'b0;
        #1;
        check("async_rvalid", DW'(rvalid), DW'(0));
        check("async_rlast", DW'(rlast), DW'(0));
        check("async_arready", DW'(arready), DW'(0));
        exp_r.delete();
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check("rel2_arready", DW'(arready), DW'(1));
        check("rel2_rvalid", DW'(rvalid), DW'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
